// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - shared types and constants for the accumulator CPU
package acc_cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  // memory responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } resp_state_t;

  // instruction opcodes (top 3 bits of an instruction word)
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_JZ  = 3'b111;

  // opcode field of an instruction word
  function automatic logic [2:0] opcode_of(input logic [DATA_W_DEF-1:0] word);
    return word[DATA_W_DEF-1 -: 3];
  endfunction

endpackage

// File: rtl/acc_mem_array.sv
// rtl/acc_mem_array.sv - single-port synchronous RAM, contents not reset
module acc_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // index width only as wide as the implemented depth needs
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  assign idx      = addr[IDX_W-1:0];
  assign in_range = {1'b0, addr} < DEPTH_W;

  // write-first is not needed: a read in the same cycle returns the old word
  always_ff @(posedge clk) begin
    if (we && in_range) mem[idx] <= din;
    dout <= in_range ? mem[idx] : '0;
  end

endmodule

// File: rtl/acc_mem_responder.sv
// rtl/acc_mem_responder.sv - request/ready memory responder with wait states
module acc_mem_responder
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0]      WAIT_LD = WAIT_CYCLES[3:0];
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  resp_state_t       state, state_nx;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic              rd_l, wr_l;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ram_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              req;
  logic              illegal;

  assign req     = mem_read | mem_write;
  // compared one bit wider so a full-size array never flags
  assign illegal = (rd_l & wr_l) | ({1'b0, addr_l} >= DEPTH_W);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (req) state_nx = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (cnt == 4'd1) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // request latch and wait counter; inputs only sampled while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      addr_l  <= '0;
      wdata_l <= '0;
      rd_l    <= 1'b0;
      wr_l    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          addr_l  <= addr;
          wdata_l <= wdata;
          rd_l    <= mem_read;
          wr_l    <= mem_write;
          cnt     <= WAIT_LD;
        end
        ST_WAIT: cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // held read data, updated as each read completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (state == ST_ACCESS && rd_l) rdata_q <= illegal ? '0 : ram_dout;
  end

  // outputs; the RAM address leads the latch in idle so zero-wait reads land in ACCESS
  always_comb begin
    ready    = (state == ST_ACCESS);
    busy     = (state != ST_IDLE);
    err      = (state == ST_ACCESS) && illegal;
    ram_we   = (state == ST_ACCESS) && wr_l && !illegal;
    ram_addr = (state == ST_IDLE) ? addr : addr_l;
    rdata    = rdata_q;
    if (state == ST_ACCESS && rd_l) rdata = illegal ? '0 : ram_dout;
  end

  acc_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (wdata_l),
    .dout (ram_dout)
  );

endmodule
